// File: rtl/kgp_alu_pkg.sv
// Shared definitions for the KGP-RISC ALU arbiter: ALU control codes and FSM state encoding.
package kgp_alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_COMP = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SHLL = 4'b0100;
  localparam logic [3:0] ALU_SHRL = 4'b0101;
  localparam logic [3:0] ALU_SHRA = 4'b0110;
  localparam int         ALU_VAR_BIT = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/alu_arb_pick.sv
// Combinational grant selector for the two ALU requesters.
// ALU_ARB_FIXED_PRIO_EN: when defined, requester 0 wins every tie; otherwise round-robin.
module alu_arb_pick (
  input  logic [1:0] req_valid,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_last_grant;
  assign unused_last_grant = last_grant;
`endif

  // Pick the winner; a tie goes to the requester not served last time.
  always_comb begin
    grant_valid = |req_valid;
    grant_idx   = 1'b0;
    case (req_valid)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
      2'b11:   grant_idx = 1'b0;
`else
      2'b11:   grant_idx = ~last_grant;
`endif
      default: grant_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one KGP-RISC ALU between the execute stage (req 0) and the branch/address unit (req 1).
// Build option ALU_ARB_FIXED_PRIO_EN (in alu_arb_pick) selects fixed priority instead of round-robin.
module alu_arbiter
  import kgp_alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5,
  parameter int CTRL_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [2*DATA_W-1:0]  req_in1,
  input  logic [2*DATA_W-1:0]  req_in2,
  input  logic [2*SHAMT_W-1:0] req_shamt,
  input  logic [2*CTRL_W-1:0]  req_ctrl,
  output logic [1:0]           resp_valid,
  input  logic [1:0]           resp_ready,
  output logic [DATA_W-1:0]    resp_out,
  output logic                 resp_flag,
  output logic [DATA_W-1:0]    alu_input1,
  output logic [DATA_W-1:0]    alu_input2,
  output logic [SHAMT_W-1:0]   alu_shamt,
  output logic [CTRL_W-1:0]    alu_control,
  input  logic [DATA_W-1:0]    alu_out,
  input  logic                 alu_flag
);

  arb_state_t         state;
  logic               grant;
  logic               last_grant;
  logic [DATA_W-1:0]  op_in1;
  logic [DATA_W-1:0]  op_in2;
  logic [SHAMT_W-1:0] op_shamt;
  logic [CTRL_W-1:0]  op_ctrl;
  logic [DATA_W-1:0]  res_out;
  logic               res_flag;
  logic               grant_valid;
  logic               grant_idx;

  alu_arb_pick u_pick (
    .req_valid   (req_valid),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Accept only the selected requester, and only while idle.
  always_comb begin
    req_ready = 2'b00;
    if (state == IDLE && grant_valid) begin
      req_ready[grant_idx] = 1'b1;
    end else begin
      req_ready = 2'b00;
    end
  end

  // Present the held result to the requester that owns it.
  always_comb begin
    resp_valid = 2'b00;
    if (state == RESP) begin
      resp_valid[grant] = 1'b1;
    end else begin
      resp_valid = 2'b00;
    end
  end

  // Transaction FSM: capture operands, sample the ALU once, hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      op_in1     <= {DATA_W{1'b0}};
      op_in2     <= {DATA_W{1'b0}};
      op_shamt   <= {SHAMT_W{1'b0}};
      op_ctrl    <= {CTRL_W{1'b0}};
      res_out    <= {DATA_W{1'b0}};
      res_flag   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            grant    <= grant_idx;
            op_in1   <= grant_idx ? req_in1[2*DATA_W-1:DATA_W]    : req_in1[DATA_W-1:0];
            op_in2   <= grant_idx ? req_in2[2*DATA_W-1:DATA_W]    : req_in2[DATA_W-1:0];
            op_shamt <= grant_idx ? req_shamt[2*SHAMT_W-1:SHAMT_W] : req_shamt[SHAMT_W-1:0];
            op_ctrl  <= grant_idx ? req_ctrl[2*CTRL_W-1:CTRL_W]    : req_ctrl[CTRL_W-1:0];
            state    <= EXEC;
          end
        end
        EXEC: begin
          res_out  <= alu_out;
          res_flag <= alu_flag;
          state    <= RESP;
        end
        RESP: begin
          if (resp_ready[grant]) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign alu_input1  = op_in1;
  assign alu_input2  = op_in2;
  assign alu_shamt   = op_shamt;
  assign alu_control = op_ctrl;
  assign resp_out    = res_out;
  assign resp_flag   = res_flag;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: transaction-level model plus directed literal checks and random traffic.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [63:0] req_in1 = 64'd0;
  logic [63:0] req_in2 = 64'd0;
  logic [9:0]  req_shamt = 10'd0;
  logic [7:0]  req_ctrl = 8'd0;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready = 2'b00;
  logic [31:0] resp_out;
  logic        resp_flag;
  logic [31:0] alu_input1, alu_input2;
  logic [4:0]  alu_shamt;
  logic [3:0]  alu_control;
  logic [31:0] alu_out;
  logic        alu_flag;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  alu_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2), .req_shamt(req_shamt), .req_ctrl(req_ctrl),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_out(resp_out), .resp_flag(resp_flag),
    .alu_input1(alu_input1), .alu_input2(alu_input2), .alu_shamt(alu_shamt),
    .alu_control(alu_control), .alu_out(alu_out), .alu_flag(alu_flag)
  );

  always #5 clk = ~clk;

  // Reference ALU: returns {flag, result}; flag is the add carry-out.
  function automatic logic [32:0] alu_f(logic [31:0] a, logic [31:0] b, logic [4:0] sh, logic [3:0] c);
    logic [31:0] o;
    logic        f;
    f = 1'b0;
    case (c)
      4'b0000: {f, o} = {1'b0, a} + {1'b0, b};
      4'b0001: o = ~b + 32'd1;
      4'b0010: o = a & b;
      4'b0011: o = a ^ b;
      4'b0100: o = a << sh;
      4'b0101: o = a >> sh;
      4'b0110: o = $signed(a) >>> sh;
      4'b1100: o = a << b[4:0];
      4'b1101: o = a >> b[4:0];
      4'b1110: o = $signed(a) >>> b[4:0];
      default: o = 32'd0;
    endcase
    return {f, o};
  endfunction

  assign {alu_flag, alu_out} = alu_f(alu_input1, alu_input2, alu_shamt, alu_control);

  // Who wins given the valid bits and who was served last; -1 if nobody asks.
  function automatic int pick(logic [1:0] v, logic last);
    if (v == 2'b00) return -1;
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    return 0;
`else
    return last ? 0 : 1;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: m_age 0 = free, 1 = ALU busy, 2 = result waiting.
  int          m_age  = 0;
  logic        m_gnt  = 1'b0;
  logic        m_last = 1'b1;
  logic [31:0] m_op1 = 32'd0, m_op2 = 32'd0, m_out = 32'd0;
  logic [4:0]  m_sh = 5'd0;
  logic [3:0]  m_ctrl = 4'd0;
  logic        m_flag = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_age <= 0; m_gnt <= 1'b0; m_last <= 1'b1;
      m_op1 <= 32'd0; m_op2 <= 32'd0; m_sh <= 5'd0; m_ctrl <= 4'd0;
      m_out <= 32'd0; m_flag <= 1'b0;
    end else if (m_age == 0) begin
      if (pick(req_valid, m_last) >= 0) begin
        m_gnt  <= (pick(req_valid, m_last) == 1);
        m_op1  <= (pick(req_valid, m_last) == 1) ? req_in1[63:32] : req_in1[31:0];
        m_op2  <= (pick(req_valid, m_last) == 1) ? req_in2[63:32] : req_in2[31:0];
        m_sh   <= (pick(req_valid, m_last) == 1) ? req_shamt[9:5] : req_shamt[4:0];
        m_ctrl <= (pick(req_valid, m_last) == 1) ? req_ctrl[7:4]  : req_ctrl[3:0];
        m_age  <= 1;
      end
    end else if (m_age == 1) begin
      {m_flag, m_out} <= alu_f(m_op1, m_op2, m_sh, m_ctrl);
      m_age <= 2;
    end else if (resp_ready[m_gnt]) begin
      m_last <= m_gnt;
      m_age  <= 0;
    end
  end

  // Every-cycle comparison of all DUT outputs against the model.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      check("req_ready", req_ready,
            (m_age == 0 && pick(req_valid, m_last) >= 0) ? 64'(2'b01 << pick(req_valid, m_last)) : 64'd0);
      check("resp_valid", resp_valid, (m_age == 2) ? 64'(2'b01 << m_gnt) : 64'd0);
      check("resp_out", resp_out, m_out);
      check("resp_flag", resp_flag, m_flag);
      check("alu_input1", alu_input1, m_op1);
      check("alu_input2", alu_input2, m_op2);
      check("alu_shamt", alu_shamt, m_sh);
      check("alu_control", alu_control, m_ctrl);
    end
  end

  // Directed-phase driver state.
  bit [1:0]    pend = 2'b00;
  bit          hold = 1'b0;
  bit          do_rst = 1'b0;
  int          n_out = 0;
  logic [31:0] d_in1 [2];
  logic [31:0] d_in2 [2];
  logic [4:0]  d_sh [2];
  logic [3:0]  d_ctrl [2];
  logic [31:0] exp_out [2];
  logic        exp_flag [2];
  int          order [$];

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [4:0] s,
                        input logic [3:0] c, input logic [31:0] eo, input logic ef);
    d_in1[i] = a; d_in2[i] = b; d_sh[i] = s; d_ctrl[i] = c;
    exp_out[i] = eo; exp_flag[i] = ef; pend[i] = 1'b1;
  endtask

  task automatic step();
    @(negedge clk);
    rst        = do_rst;
    req_valid  = pend;
    req_in1    = {d_in1[1], d_in1[0]};
    req_in2    = {d_in2[1], d_in2[0]};
    req_shamt  = {d_sh[1], d_sh[0]};
    req_ctrl   = {d_ctrl[1], d_ctrl[0]};
    resp_ready = hold ? 2'b00 : 2'b11;
    #2;
    for (int i = 0; i < 2; i++) begin
      if (req_ready[i] && req_valid[i]) begin
        pend[i] = 1'b0;
        n_out++;
      end
      if (resp_valid[i]) begin
        check($sformatf("lit_out%0d", i), resp_out, exp_out[i]);
        check($sformatf("lit_flag%0d", i), resp_flag, exp_flag[i]);
        if (resp_ready[i]) begin
          order.push_back(i);
          n_out--;
        end
      end
    end
  endtask

  task automatic run_done();
    int budget;
    budget = 40;
    while ((pend != 2'b00 || n_out > 0) && budget > 0) begin
      step();
      budget--;
    end
    check("run_budget", 64'(budget > 0), 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      d_in1[i] = 32'd0; d_in2[i] = 32'd0; d_sh[i] = 5'd0; d_ctrl[i] = 4'd0;
      exp_out[i] = 32'd0; exp_flag[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #2;
    check("rst_req_ready", req_ready, 64'd0);
    check("rst_resp_valid", resp_valid, 64'd0);
    check("rst_alu_input1", alu_input1, 64'd0);
    check("rst_resp_out", resp_out, 64'd0);

    // Single add with latency checks.
    set_op(0, 32'd105, 32'd106, 5'd0, 4'b0000, 32'd211, 1'b0);
    step();
    check("add_req_ready", req_ready, 64'h1);
    step();
    check("add_exec_no_resp", resp_valid, 64'h0);
    check("add_exec_alu_in1", alu_input1, 64'd105);
    step();
    check("add_resp_valid", resp_valid, 64'h1);
    run_done();
    step();
    check("add_back_idle", resp_valid, 64'h0);

    // Carry out of requester 1.
    set_op(1, 32'h8000_0000, 32'h8000_0000, 5'd0, 4'b0000, 32'd0, 1'b1);
    order.delete();
    run_done();
    check("carry_served", 64'(order.size()), 64'd1);

    // Simultaneous requests: requester 0 first after requester 1 was served last.
    set_op(0, 32'hFFFF_FF89, 32'd0, 5'd4, 4'b0110, 32'hFFFF_FFF8, 1'b0);
    set_op(1, 32'hFFFF_FEFD, 32'd8, 5'd0, 4'b1100, 32'hFFFE_FD00, 1'b0);
    order.delete();
    run_done();
    check("tie_count", 64'(order.size()), 64'd2);
    if (order.size() == 2) begin
      check("tie_first", 64'(order[0]), 64'd0);
      check("tie_second", 64'(order[1]), 64'd1);
    end

    // Back-pressure: result held, requester 1 waits.
    set_op(0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd0, 4'b0011, 32'hFF00_FF00, 1'b0);
    hold = 1'b1;
    for (int k = 0; k < 10 && resp_valid != 2'b01; k++) step();
    check("bp_resp_seen", resp_valid, 64'h1);
    set_op(1, 32'hFFFF_0000, 32'h1234_5678, 5'd0, 4'b0010, 32'h1234_0000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      step();
      check("bp_req_ready", req_ready, 64'h0);
      check("bp_resp_valid", resp_valid, 64'h1);
    end
    hold = 1'b0;
    step();
    step();
    check("bp_release_idle", req_ready, 64'h2);
    run_done();

    // Reset during EXEC aborts the transaction.
    set_op(0, 32'd1, 32'd2, 5'd0, 4'b0000, 32'd3, 1'b0);
    step();
    check("rx_handshake", req_ready, 64'h1);
    do_rst = 1'b1;
    step();
    do_rst = 1'b0;
    n_out = 0;
    step();
    check("rx_resp_valid", resp_valid, 64'h0);
    check("rx_resp_out", resp_out, 64'h0);
    check("rx_alu_input1", alu_input1, 64'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("rx_no_resp", resp_valid, 64'h0);
    end
    set_op(0, 32'd7, 32'd8, 5'd0, 4'b0000, 32'd15, 1'b0);
    run_done();

    // Starvation: both always asking, grants must alternate.
    order.delete();
    for (int r = 0; r < 5; r++) begin
      set_op(0, 32'(r * 3), 32'd100, 5'd0, 4'b0000, 32'(r * 3 + 100), 1'b0);
      set_op(1, 32'(r * 7), 32'd200, 5'd0, 4'b0000, 32'(r * 7 + 200), 1'b0);
      run_done();
    end
    check("starve_count", 64'(order.size()), 64'd10);
`ifdef ALU_ARB_FIXED_PRIO_EN
    if (order.size() > 0) check("starve_first", 64'(order[0]), 64'd0);
`else
    if (order.size() > 0) check("starve_first", 64'(order[0]), 64'd1);
`endif
    for (int k = 1; k < order.size(); k++) begin
      check("starve_alt", 64'(order[k] != order[k-1]), 64'd1);
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst        = ($urandom_range(0, 99) == 0);
      req_valid  = 2'($urandom);
      req_in1    = {$urandom, $urandom};
      req_in2    = {$urandom, $urandom};
      req_shamt  = 10'($urandom);
      req_ctrl   = 8'($urandom);
      resp_ready = 2'($urandom);
    end
    @(negedge clk);
    rst = 1'b0;
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
